// File: rtl/ds_pkg.sv
// rtl/ds_pkg.sv - shared FSM state type and default geometry for downsample_engine
package ds_pkg;

  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 256;
  localparam int DEF_PIX_W  = 8;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } ds_state_e;

endpackage

// File: rtl/ds_addr_gen.sv
// rtl/ds_addr_gen.sv - raster 2x2 block counters plus source/result address generation
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              advance,
  input  logic [1:0]        phase,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_block
);

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  logic [COL_W-1:0] ocol_q, ocol_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic [COL_W:0]   rd_col;
  logic [ROW_W:0]   rd_row;

  wire col_last = (ocol_q == COL_W'(OUT_W - 1));
  wire row_last = (orow_q == ROW_W'(OUT_H - 1));

  always_comb begin
    ocol_d = ocol_q;
    orow_d = orow_q;
    if (advance) begin
      if (col_last) begin
        ocol_d = '0;
        orow_d = row_last ? '0 : orow_q + ROW_W'(1);
      end else begin
        ocol_d = ocol_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ocol_q <= '0;
      orow_q <= '0;
    end else begin
      ocol_q <= ocol_d;
      orow_q <= orow_d;
    end
  end

  // phase[0] selects the right column, phase[1] the bottom row: TL, TR, BL, BR
  assign rd_col     = {ocol_q, phase[0]};
  assign rd_row     = {orow_q, phase[1]};
  assign rd_addr    = ADDR_W'(rd_row) * ADDR_W'(IMG_W) + ADDR_W'(rd_col);
  assign wr_addr    = ADDR_W'(orow_q) * ADDR_W'(OUT_W) + ADDR_W'(ocol_q);
  assign last_block = col_last && row_last;

endmodule

// File: rtl/downsample_engine.sv
// rtl/downsample_engine.sv - 2x2 image downsampler, 6 cycles per output pixel
// DS_AVERAGE_EN selects rounded 2x2 averaging; otherwise TL-pixel decimation.
module downsample_engine
  import ds_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              end_process
);

`ifdef DS_AVERAGE_EN
  localparam int ACC_W = PIX_W + 2;
`else
  localparam int ACC_W = PIX_W;
`endif

  ds_state_e         state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              advance;
  logic              last_block;
  logic [ADDR_W-1:0] gen_rd_addr, gen_wr_addr;
  logic [PIX_W-1:0]  block_result;

  ds_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clock      (clock),
    .reset_n    (reset_n),
    .advance    (advance),
    .phase      (phase_q),
    .rd_addr    (gen_rd_addr),
    .wr_addr    (gen_wr_addr),
    .last_block (last_block)
  );

  always_comb begin
    state_d = state_q;
    phase_d = 2'd0;
    advance = 1'b0;
    case (state_q)
      IDLE:  if (enable) state_d = FETCH;
      FETCH: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: state_d = WRITE;
      WRITE: begin
        advance = 1'b1;
        state_d = last_block ? DONE : FETCH;
      end
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // read data trails rd_en by one cycle, so phases 1..3 and DRAIN see TL..BR
  always_comb begin
    acc_d = acc_q;
`ifdef DS_AVERAGE_EN
    if (state_q == FETCH && phase_q == 2'd0)
      acc_d = '0;
    else if (state_q == FETCH || state_q == DRAIN)
      acc_d = acc_q + ACC_W'(rd_data);
`else
    if (state_q == FETCH && phase_q == 2'd0)
      acc_d = '0;
    else if (state_q == FETCH && phase_q == 2'd1)
      acc_d = rd_data;
`endif
  end

`ifdef DS_AVERAGE_EN
  assign block_result = PIX_W'((acc_q + ACC_W'(2)) >> 2);
`else
  assign block_result = acc_q;
`endif

  assign rd_en       = (state_q == FETCH);
  assign wr_en       = (state_q == WRITE);
  assign end_process = (state_q == DONE);

  always_comb begin
    rd_addr_d = rd_en ? gen_rd_addr  : rd_addr_q;
    wr_addr_d = wr_en ? gen_wr_addr  : wr_addr_q;
    wr_data_d = wr_en ? block_result : wr_data_q;
  end

  assign rd_addr = rd_addr_d;
  assign wr_addr = wr_addr_d;
  assign wr_data = wr_data_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= 2'd0;
      acc_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
